// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the sequential ALU: opcodes, FSM states,
// and the flag bundle registered alongside the result.
package alu_seq_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_SHL = 4'd5,
        OP_SHR = 4'd6,
        OP_SRA = 4'd7,
        OP_MUL = 4'd8
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic zero;
        logic negative;
        logic carry;
        logic overflow;
        logic err;
    } flags_t;

    // Highest legal opcode; anything above is reported through err.
    localparam op_e OP_LAST = OP_MUL;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative unsigned shift-add multiplier. The start edge captures the
// operands and performs the first partial-product step, so the product is
// complete after exactly WIDTH iteration edges; done pulses for one cycle.
module alu_seq_mul #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [SHW-1:0]     cnt;

    // Operand capture on start, then one shift-add step per busy cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                acc    <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
                mcand  <= {{(WIDTH-1){1'b0}}, a, 1'b0};
                mplier <= b >> 1;
                cnt    <= SHW'(WIDTH-1);
                busy   <= 1'b1;
            end else if (busy) begin
                acc    <= acc + (mplier[0] ? mcand : '0);
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt - SHW'(1);
                if (cnt == SHW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign product = acc;

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU with registered result and flags. Single-cycle ops are
// evaluated combinationally from the presented operands and loaded at the
// accepting edge; MUL is delegated to the iterative multiplier.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             negative,
    output logic             carry,
    output logic             overflow,
    output logic             err
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   result_q;
    flags_t             flags_q;

    logic               load_alu;
    logic               load_mul;
    logic               mul_start;
    logic               mul_busy;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;

    logic [WIDTH-1:0]   alu_res;
    flags_t             alu_flags;
    flags_t             mul_flags;

    // Shift helpers carry one extra bit that catches the last bit shifted out.
    logic [WIDTH:0]     sum_add;
    logic [WIDTH:0]     sum_sub;
    logic [WIDTH:0]     shl_ext;
    logic [WIDTH:0]     shr_ext;
    logic [WIDTH:0]     sra_ext;
    logic               b_over;
    logic               is_mul;

    assign sum_add = {1'b0, a} + {1'b0, b};
    assign sum_sub = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
    assign shl_ext = {1'b0, a} << b;
    assign shr_ext = {a, 1'b0} >> b;
    assign sra_ext = $signed({a, 1'b0}) >>> b;
    assign b_over  = {1'b0, b} > (WIDTH+1)'(WIDTH);
    assign is_mul  = (op == OP_MUL);

    // Single-cycle datapath: result and flags for the presented opcode.
    always_comb begin
        alu_res   = '0;
        alu_flags = '0;
        case (op)
            OP_ADD: begin
                alu_res            = sum_add[WIDTH-1:0];
                alu_flags.carry    = sum_add[WIDTH];
                alu_flags.overflow = (a[WIDTH-1] == b[WIDTH-1]) &&
                                     (alu_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res            = sum_sub[WIDTH-1:0];
                alu_flags.carry    = sum_sub[WIDTH];
                alu_flags.overflow = (a[WIDTH-1] != b[WIDTH-1]) &&
                                     (alu_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_XOR: alu_res = a ^ b;
            OP_SHL: begin
                alu_res         = shl_ext[WIDTH-1:0];
                alu_flags.carry = shl_ext[WIDTH];
            end
            OP_SHR: begin
                alu_res         = shr_ext[WIDTH:1];
                alu_flags.carry = shr_ext[0];
            end
            OP_SRA: begin
                if (b_over) begin
                    alu_res         = {WIDTH{a[WIDTH-1]}};
                    alu_flags.carry = 1'b0;
                end else begin
                    alu_res         = sra_ext[WIDTH:1];
                    alu_flags.carry = sra_ext[0];
                end
            end
            default: begin
                alu_res       = '0;
                alu_flags.err = (op > OP_LAST);
            end
        endcase
        alu_flags.zero     = ~|alu_res;
        alu_flags.negative = alu_res[WIDTH-1];
    end

    // Flags derived from the finished multiplier product.
    always_comb begin
        mul_flags          = '0;
        mul_flags.zero     = ~|mul_product[WIDTH-1:0];
        mul_flags.negative = mul_product[WIDTH-1];
        mul_flags.carry    = |mul_product[2*WIDTH-1:WIDTH];
    end

    assign in_ready  = ~mul_busy &
                       ((state_q == IDLE) | ((state_q == DONE) & out_ready));
    assign out_valid = (state_q == DONE);

    // Next-state and load strobes; DONE can hand off and accept in one edge.
    always_comb begin
        state_d   = state_q;
        load_alu  = 1'b0;
        load_mul  = 1'b0;
        mul_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    if (is_mul) begin
                        mul_start = 1'b1;
                        state_d   = BUSY;
                    end else begin
                        load_alu = 1'b1;
                        state_d  = DONE;
                    end
                end
            end
            BUSY: begin
                if (mul_done) begin
                    load_mul = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    if (in_valid && in_ready) begin
                        if (is_mul) begin
                            mul_start = 1'b1;
                            state_d   = BUSY;
                        end else begin
                            load_alu = 1'b1;
                            state_d  = DONE;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Output registers; held unchanged unless a load strobe fires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            flags_q  <= '0;
        end else if (load_alu) begin
            result_q <= alu_res;
            flags_q  <= alu_flags;
        end else if (load_mul) begin
            result_q <= mul_product[WIDTH-1:0];
            flags_q  <= mul_flags;
        end
    end

    assign result   = result_q;
    assign zero     = flags_q.zero;
    assign negative = flags_q.negative;
    assign carry    = flags_q.carry;
    assign overflow = flags_q.overflow;
    assign err      = flags_q.err;

    alu_seq_mul #(
        .WIDTH(WIDTH),
        .SHW  (SHW)
    ) u_mul (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (mul_start),
        .a      (a),
        .b      (b),
        .busy   (mul_busy),
        .done   (mul_done),
        .product(mul_product)
    );

endmodule

// File: tb/tb_alu_seq.sv
// Directed testbench for alu_seq at WIDTH=8 with hand-computed expectations.
module tb_alu_seq;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] op;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       zero;
    logic       negative;
    logic       carry;
    logic       overflow;
    logic       err;

    int n_cmp = 0;
    int n_err = 0;

    alu_seq #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .op       (op),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .zero     (zero),
        .negative (negative),
        .carry    (carry),
        .overflow (overflow),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present an op, wait for in_ready, return #1 after the accepting edge
    // with in_valid dropped and the operand inputs scrambled.
    task automatic issue(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
        int w;
        w = 0;
        in_valid = 1'b1;
        op = o;
        a = x;
        b = y;
        #1;
        while (!in_ready && w < 50) begin
            @(posedge clk);
            #1;
            w++;
        end
        check("accept_wait", 32'(w < 50), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op = 4'hF;
        a = 8'hA5;
        b = 8'h5A;
    endtask

    // Flags are compared as {zero, negative, carry, overflow, err}.
    task automatic run_op(input string tag, input logic [3:0] o, input logic [7:0] x,
                          input logic [7:0] y, input logic [7:0] exp_res,
                          input logic [4:0] exp_fl, input int exp_lat);
        int lat;
        int rdy_busy;
        out_ready = 1'b1;
        issue(o, x, y);
        lat = 1;
        rdy_busy = 0;
        while (!out_valid && lat < 50) begin
            if (in_ready) rdy_busy++;
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_rdy_busy"}, rdy_busy, 0);
        check({tag, "_res"}, result, exp_res);
        check({tag, "_flg"}, {zero, negative, carry, overflow, err}, exp_fl);
    endtask

    initial begin
        int seen;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        op = 4'h0;
        a = 8'h00;
        b = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("rst_res", result, 8'h00);
        check("rst_flg", {zero, negative, carry, overflow, err}, 5'b00000);
        check("rst_ovalid", out_valid, 0);
        check("rst_iready", in_ready, 1);

        run_op("add_ff_01", 4'd0, 8'hFF, 8'h01, 8'h00, 5'b10100, 1);
        run_op("add_7f_01", 4'd0, 8'h7F, 8'h01, 8'h80, 5'b01010, 1);
        run_op("sub_80_01", 4'd1, 8'h80, 8'h01, 8'h7F, 5'b00110, 1);
        run_op("sub_01_02", 4'd1, 8'h01, 8'h02, 8'hFF, 5'b01000, 1);
        run_op("and",       4'd2, 8'hCC, 8'hAA, 8'h88, 5'b01000, 1);
        run_op("or",        4'd3, 8'h0C, 8'h03, 8'h0F, 5'b00000, 1);
        run_op("mul_10_12", 4'd8, 8'h10, 8'h12, 8'h20, 5'b00100, 9);
        run_op("mul_ff_ff", 4'd8, 8'hFF, 8'hFF, 8'h01, 5'b00100, 9);
        run_op("mul_07_06", 4'd8, 8'h07, 8'h06, 8'h2A, 5'b00000, 9);
        run_op("sra_90_3",  4'd7, 8'h90, 8'd3,  8'hF2, 5'b01000, 1);
        run_op("sra_80_8",  4'd7, 8'h80, 8'd8,  8'hFF, 5'b01100, 1);
        run_op("sra_80_9",  4'd7, 8'h80, 8'd9,  8'hFF, 5'b01000, 1);
        run_op("shl_81_1",  4'd5, 8'h81, 8'd1,  8'h02, 5'b00100, 1);
        run_op("shl_01_8",  4'd5, 8'h01, 8'd8,  8'h00, 5'b10100, 1);
        run_op("shr_81_9",  4'd6, 8'h81, 8'd9,  8'h00, 5'b10000, 1);
        run_op("shr_80_0",  4'd6, 8'h80, 8'd0,  8'h80, 5'b01000, 1);
        run_op("shr_81_1",  4'd6, 8'h81, 8'd1,  8'h40, 5'b00100, 1);
        run_op("illegal_f", 4'hF, 8'h12, 8'h34, 8'h00, 5'b10001, 1);

        // Drain so the next op starts from IDLE under backpressure.
        @(posedge clk);
        #1;
        check("drain_ovalid", out_valid, 0);

        out_ready = 1'b0;
        issue(4'd0, 8'h03, 8'h04);
        check("bp_ovalid_first", out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_res", result, 8'h07);
            check("bp_hold_ovalid", out_valid, 1);
            check("bp_hold_iready", in_ready, 0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        in_valid = 1'b1;
        op = 4'd4;
        a = 8'hF0;
        b = 8'h0F;
        #1;
        check("b2b_iready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("b2b_ovalid", out_valid, 1);
        check("b2b_res", result, 8'hFF);
        check("b2b_flg", {zero, negative, carry, overflow, err}, 5'b01000);
        @(posedge clk);
        #1;
        check("b2b_drained", out_valid, 0);

        // Reset during the fourth busy cycle of a multiply.
        issue(4'd8, 8'h10, 8'h12);
        repeat (3) @(posedge clk);
        #1;
        check("mid_busy_iready", in_ready, 0);
        rst_n = 1'b0;
        #1;
        check("mrst_res", result, 8'h00);
        check("mrst_flg", {zero, negative, carry, overflow, err}, 5'b00000);
        check("mrst_ovalid", out_valid, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("mrst_iready", in_ready, 1);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("mrst_no_ovalid", seen, 0);
        check("mrst_res_after", result, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor of the team's 8-bit combinational ALU.
- Adds registered outputs, valid/ready flow control, a full flag set (zero/negative/carry/overflow/err), arithmetic shift and variable shift amounts.
- Adds an iterative multi-cycle multiply.
- Sits between an operand-issue stage and a writeback stage in the datapath.

Parameters:
- WIDTH, 8, operand/result width in bits (≥4).
- SHW, $clog2(WIDTH), derived; width of the internal shift counter.

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands and op presented.
- in_ready  out  1  block can accept a new operation.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B; for shifts, the unsigned shift amount.
- op  in  4  operation code (alu_seq_pkg::op_e).
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer takes the result.
- result  out  WIDTH  registered result.
- zero  out  1  result == 0.
- negative  out  1  result[WIDTH-1].
- carry  out  1  carry/borrow/shift-out, per op.
- overflow  out  1  signed overflow.
- err  out  1  illegal opcode.

Behaviour:
- Clocking and reset: one clock domain. Reset is asynchronous and active-low: clk and rst_n as named above.
- Reset values: state=IDLE; out_valid=0; result, zero, negative, carry, overflow and err all 0; in_ready=1 once rst_n=1.
- Reset mid-operation: an in-flight MUL or unconsumed result is discarded; no out_valid pulse follows release.
- State machine: IDLE, BUSY, DONE.
  - IDLE: in_valid&in_ready accepts.
    - Single-cycle ops go to DONE; output registers load at the accepting edge, so out_valid is seen the next cycle (latency 1).
    - MUL goes to BUSY.
  - BUSY: one shift-add iteration per cycle for WIDTH cycles, then DONE. out_valid rises WIDTH+1 cycles after acceptance.
  - DONE: out_valid=1 and outputs held stable until out_valid&out_ready.
    - If in_valid is also high in that cycle, the new op is accepted in the same edge (back-to-back, no bubble).
    - Otherwise the block returns to IDLE.
- in_ready = (state==IDLE) | (state==DONE & out_ready). in_ready is 0 in BUSY.
- Operand capture: a, b and op are sampled only at acceptance; later input changes have no effect.
- Opcodes:
  - 0 ADD: result = a+b mod 2^WIDTH; carry = carry-out; overflow = signed overflow.
  - 1 SUB: result = a-b via a+~b+1; carry = 1 when there is no borrow (a≥b unsigned); overflow = signed overflow.
  - 2 AND, 3 OR, 4 XOR: bitwise; carry=0, overflow=0.
  - 5 SHL, 6 SHR (logical), 7 SRA (sign-fill): shift amount is the full unsigned value of b.
    - b==0: result=a, carry=0.
    - 0<b≤WIDTH: carry = last bit shifted out.
    - b≥WIDTH: result=0 (SRA: all bits = a[WIDTH-1]); carry=0 when b>WIDTH.
    - overflow=0 for all shifts.
  - 8 MUL: unsigned; result = low WIDTH bits of a*b; carry = |(high WIDTH bits); overflow=0.
  - 9–15 illegal: result=0, err=1, carry=0, overflow=0; handshake still completes with latency 1.
- Flags for every op: zero = ~|result; negative = result[WIDTH-1]. err=0 for legal ops.

Decomposition:
- Package alu_seq_pkg:
  - op_e: 4-bit enum OP_ADD … OP_MUL.
  - state_e: IDLE, BUSY, DONE.
  - flags_t: packed struct {zero, negative, carry, overflow, err}.
  - Constant OP_LAST = OP_MUL.
- Sub-module alu_seq_mul: iterative shift-add multiplier.
  - Ports: clk, rst_n, start, a, b, busy, done, product[2*WIDTH-1:0].
  - Exactly WIDTH iteration cycles.
- Single-cycle ops are combinational inside alu_seq, feeding the output registers.

Test Plan:
- WIDTH=8, ADD a=0xFF b=0x01 -> result 0x00, zero=1, carry=1, overflow=0, negative=0; out_valid exactly 1 cycle after accept.
- SUB a=0x80 b=0x01 -> result 0x7F, carry=1, overflow=1, negative=0. SUB a=0x01 b=0x02 -> result 0xFF, carry=0, negative=1.
- MUL a=0x10 b=0x12 -> result 0x20, carry=1; in_ready=0 throughout BUSY; out_valid rises exactly 9 cycles after accept.
- Shifts:
  - SRA a=0x90 b=3 -> result 0xF2, carry=0, negative=1.
  - SHL a=0x81 b=1 -> result 0x02, carry=1.
  - SHR a=0x81 b=9 -> result 0x00, carry=0, zero=1.
- Backpressure: ADD 3+4 accepted, out_ready=0 for 5 cycles -> result 0x07 held, in_ready=0. Then out_ready=1 with a new in_valid XOR 0xF0^0x0F -> both handshakes in one edge; next cycle result 0xFF.
- Reset/illegal:
  - rst_n low during cycle 4 of a MUL -> all outputs 0, in_ready=1 after release, no out_valid.
  - op=4'hF -> result 0x00, err=1, zero=1.
